// File: rtl/territory_tally.sv
// territory_tally: sweeps the 160x120 paint RAM after a round and
// counts pixels per player colour, then reports the winner.
//
// Ports:
//   CLOCK_50, resetn      clock, async active-low reset
//   start                 tally request (taken only when idle)
//   rd_addr / rd_q        RAM read port {x[7:0], y[6:0]} / colour
//   busy, done            tally in progress / one-cycle completion pulse
//   p1..p4_count          per-player pixel totals
//   winner, tie           index of largest count, shared-maximum flag
module territory_tally #(
  parameter int RD_LAT = 1,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_q,
  output logic        busy,
  output logic        done,
  output logic [14:0] p1_count,
  output logic [14:0] p2_count,
  output logic [14:0] p3_count,
  output logic [14:0] p4_count,
  output logic [1:0]  winner,
  output logic        tie
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    CMP,
    FIN
  } state_t;

  localparam logic [7:0] XL = 8'(X_MAX);
  localparam logic [6:0] YL = 7'(Y_MAX);
  localparam logic [1:0] DRN_INIT = 2'(RD_LAT - 1);

  state_t state_q;
  state_t state_d;

  logic [14:0]       cnt_q [4];
  logic [RD_LAT-1:0] vld_q;
  logic [1:0]        drn_q;
  logic [3:0]        hit;
  logic [7:0]        x;
  logic [6:0]        y;
  logic              last;
  logic              issue;
  logic [14:0]       best;
  logic [1:0]        widx;
  logic [2:0]        nmax;
  logic              tie_d;

  assign x     = rd_addr[14:7];
  assign y     = rd_addr[6:0];
  assign last  = (x == XL) && (y == YL);
  assign issue = (state_q == SCAN);

  assign p1_count = cnt_q[0];
  assign p2_count = cnt_q[1];
  assign p3_count = cnt_q[2];
  assign p4_count = cnt_q[3];

  always_comb begin
    hit = '0;
    unique case (1'b1)
      rd_q == 3'b001: hit[0] = 1'b1;
      rd_q == 3'b010: hit[1] = 1'b1;
      rd_q == 3'b100: hit[2] = 1'b1;
      rd_q == 3'b110: hit[3] = 1'b1;
      default: ;
    endcase
  end

  // Strict '>' keeps the lowest index on equal maxima.
  always_comb begin
    best = cnt_q[0];
    widx = 2'd0;
    nmax = 3'd0;
    for (int i = 1; i < 4; i++) begin
      if (cnt_q[i] > best) begin
        best = cnt_q[i];
        widx = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (cnt_q[i] == best) nmax = nmax + 3'd1;
    end
    tie_d = (nmax > 3'd1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last) state_d = DRAIN;
      DRAIN:   if (drn_q == 2'd0) state_d = CMP;
      CMP:     state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      winner  <= 2'd0;
      tie     <= 1'b0;
      vld_q   <= '0;
      drn_q   <= 2'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      done <= (state_q == CMP);
      // Tags each issued address so rd_q is
      // only counted RD_LAT cycles later.
      vld_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++)
        vld_q[i] <= vld_q[i-1];
      if (vld_q[RD_LAT-1]) begin
        for (int i = 0; i < 4; i++)
          if (hit[i]) cnt_q[i] <= cnt_q[i] + 15'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            rd_addr <= '0;
            for (int i = 0; i < 4; i++)
              cnt_q[i] <= '0;
          end
        end
        SCAN: begin
          if (last)
            drn_q <= DRN_INIT;
          else if (y == YL)
            rd_addr <= {x + 8'd1, 7'd0};
          else
            rd_addr <= {x, y + 7'd1};
        end
        DRAIN: begin
          if (drn_q != 2'd0) drn_q <= drn_q - 2'd1;
        end
        CMP: begin
          busy   <= 1'b0;
          winner <= widx;
          tie    <= tie_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_territory_tally.sv
// tb_territory_tally: scoreboard bench running RD_LAT=1 and RD_LAT=2
// instances side by side against a behavioural paint RAM.
module tb_territory_tally;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        resetn;
  logic        start [2];
  logic [14:0] addr  [2];
  logic [2:0]  q     [2];
  logic        busy  [2];
  logic        done  [2];
  logic [14:0] c1    [2];
  logic [14:0] c2    [2];
  logic [14:0] c3    [2];
  logic [14:0] c4    [2];
  logic [1:0]  win   [2];
  logic        tie   [2];

  int cyc = 0;
  int mode = 0;
  int tests = 0;
  int fails = 0;
  int viol = 0;

  typedef struct {
    int p1, p2, p3, p4, w, t, dc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  territory_tally #(.RD_LAT(1)) u_l1 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start[0]),
    .rd_addr(addr[0]), .rd_q(q[0]), .busy(busy[0]), .done(done[0]),
    .p1_count(c1[0]), .p2_count(c2[0]), .p3_count(c3[0]),
    .p4_count(c4[0]), .winner(win[0]), .tie(tie[0])
  );

  territory_tally #(.RD_LAT(2)) u_l2 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start[1]),
    .rd_addr(addr[1]), .rd_q(q[1]), .busy(busy[1]), .done(done[1]),
    .p1_count(c1[1]), .p2_count(c2[1]), .p3_count(c3[1]),
    .p4_count(c4[1]), .winner(win[1]), .tie(tie[1])
  );

  // mode 0: all background
  // mode 1: column 0 = p1, columns 1..3 = p2
  // mode 2: uncounted filler, (0,0)=p3, (159,119)=p4,
  //         hidden rows 120..127 = p1
  function automatic logic [2:0] pix(input logic [14:0] a);
    int x;
    int y;
    x = int'(a[14:7]);
    y = int'(a[6:0]);
    if (mode == 0) return 3'b000;
    if (mode == 1) begin
      if (x == 0) return 3'b001;
      if (x <= 3) return 3'b010;
      return 3'b000;
    end
    if (y >= 120) return 3'b001;
    if (x == 0 && y == 0) return 3'b100;
    if (x == 159 && y == 119) return 3'b110;
    case ((x + y) % 3)
      0:       return 3'b011;
      1:       return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  logic [2:0] s2;
  always @(posedge CLOCK_50) begin
    q[0] <= pix(addr[0]);
    s2   <= pix(addr[1]);
    q[1] <= s2;
  end

  task automatic chk(input string n, input int d,
                     input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d expected %0d", n, d, a, e);
    end
  endtask

  int  bcnt  [2] = '{0, 0};
  bit  pbusy [2] = '{0, 0};

  always @(negedge CLOCK_50) begin
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        bcnt[d]  = 0;
        pbusy[d] = 1'b0;
      end else begin
        exp_t e;
        bit   have;
        if (addr[d][6:0] > 7'd119 || addr[d] > 15'h4FF7) viol++;
        if (busy[d]) bcnt[d]++;
        if (busy[d] && !pbusy[d])
          chk("first_addr", d, int'(addr[d]), 0);
        if (done[d]) begin
          have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
          if (!have) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done dut%0d at cycle %0d", d, cyc);
          end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("p1_count", d, int'(c1[d]), e.p1);
            chk("p2_count", d, int'(c2[d]), e.p2);
            chk("p3_count", d, int'(c3[d]), e.p3);
            chk("p4_count", d, int'(c4[d]), e.p4);
            chk("winner", d, int'(win[d]), e.w);
            chk("tie", d, int'(tie[d]), e.t);
            chk("done_cycle", d, cyc, e.dc);
            chk("busy_len", d, bcnt[d], 19202 + d);
            chk("busy_at_done", d, int'(busy[d]), 0);
            chk("last_addr", d, int'(addr[d]), 'h4FF7);
          end
          bcnt[d] = 0;
        end
        pbusy[d] = busy[d];
      end
    end
  end

  task automatic issue(input int m, input int p1, input int p2,
                       input int p3, input int p4, input int w,
                       input int t, output int k);
    exp_t e;
    mode = m;
    @(negedge CLOCK_50);
    k = cyc;
    e = '{p1, p2, p3, p4, w, t, k + 19203};
    sb0.push_back(e);
    e.dc = k + 19204;
    sb1.push_back(e);
    start[0] = 1'b1;
    start[1] = 1'b1;
    @(negedge CLOCK_50);
    start[0] = 1'b0;
    start[1] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 25000; i++) begin
      if (sb0.size() == 0 && sb1.size() == 0) break;
      @(negedge CLOCK_50);
    end
    if (sb0.size() != 0 || sb1.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: pending %0d/%0d expected %0d",
               sb0.size(), sb1.size(), 0);
      sb0.delete();
      sb1.delete();
    end
    repeat (30) @(negedge CLOCK_50);
    for (int d = 0; d < 2; d++)
      chk("idle_busy", d, int'(busy[d]), 0);
  endtask

  task automatic chk_zero(input string n);
    for (int d = 0; d < 2; d++) begin
      chk({n, "_addr"}, d, int'(addr[d]), 0);
      chk({n, "_busy"}, d, int'(busy[d]), 0);
      chk({n, "_done"}, d, int'(done[d]), 0);
      chk({n, "_p1"}, d, int'(c1[d]), 0);
      chk({n, "_p2"}, d, int'(c2[d]), 0);
      chk({n, "_p3"}, d, int'(c3[d]), 0);
      chk({n, "_p4"}, d, int'(c4[d]), 0);
      chk({n, "_winner"}, d, int'(win[d]), 0);
      chk({n, "_tie"}, d, int'(tie[d]), 0);
    end
  endtask

  initial begin
    int k;
    resetn   = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk_zero("reset");
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // empty canvas: all-zero tie
    issue(0, 0, 0, 0, 0, 0, 1, k);
    wait_idle();

    // columns; extra starts mid-scan and in each done cycle
    issue(1, 120, 360, 0, 0, 1, 0, k);
    while (cyc < k + 3000) @(negedge CLOCK_50);
    start[0] = 1'b1;
    start[1] = 1'b1;
    @(negedge CLOCK_50);
    start[0] = 1'b0;
    start[1] = 1'b0;
    while (cyc < k + 19203) @(negedge CLOCK_50);
    start[0] = 1'b1;
    @(negedge CLOCK_50);
    start[0] = 1'b0;
    start[1] = 1'b1;
    @(negedge CLOCK_50);
    start[1] = 1'b0;
    wait_idle();

    // reset mid-scan: outputs clear at once, no done
    issue(1, 120, 360, 0, 0, 1, 0, k);
    while (cyc < k + 5000) @(negedge CLOCK_50);
    for (int d = 0; d < 2; d++)
      chk("midscan_busy", d, int'(busy[d]), 1);
    @(posedge CLOCK_50);
    #2 resetn = 1'b0;
    #1;
    chk_zero("abort");
    sb0.delete();
    sb1.delete();
    @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #5 resetn = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    // restart reproduces the column result
    issue(1, 120, 360, 0, 0, 1, 0, k);
    wait_idle();

    // corners + filler + hidden rows
    issue(2, 0, 0, 1, 1, 2, 1, k);
    wait_idle();

    chk("addr_range_violations", 0, viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
